// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge) and asynchronous active-low reset
//   i_start             request, sampled only while idle
//   i_dividend          WIDTH-bit unsigned dividend, captured on an accepted start
//   i_divisor           WIDTH-bit unsigned divisor, captured on an accepted start
//   o_busy              high while a division is in progress
//   o_done              single-cycle pulse, results valid from this cycle
//   o_quotient          registered quotient, held until the next completion
//   o_remainder         registered remainder, held until the next completion
//   o_div_by_zero       registered flag, the captured divisor was zero
//
// Latency is WIDTH+1 edges from the accepted start to the o_done cycle,
// independent of operand values. Division by zero needs no special case:
// every trial subtract succeeds, giving an all-ones quotient and
// remainder equal to the dividend.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   trial_c;
  logic [WIDTH:0]   diff_c;
  logic             qbit_c;
  logic             last_c;
  logic [WIDTH-1:0] rem_next_c;
  logic [WIDTH-1:0] shift_next_c;

  // One restoring step. A surviving partial remainder is always below the
  // divisor, so its top bit is zero and only WIDTH bits need storing.
  always_comb begin
    trial_c      = {rem_q, shift_q[WIDTH-1]};
    diff_c       = trial_c + ~{1'b0, divisor_q} + (WIDTH + 1)'(1);
    qbit_c       = ~diff_c[WIDTH];
    rem_next_c   = qbit_c ? diff_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
    shift_next_c = {shift_q[WIDTH-2:0], qbit_c};
    last_c       = (count_q == LAST_STEP);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = CALC;
      CALC:    if (last_c)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q       <= '0;
      divisor_q     <= '0;
      shift_q       <= '0;
      rem_q         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_busy <= (state_d == CALC);
      case (state_q)
        IDLE: begin
          if (i_start) begin
            divisor_q <= i_divisor;
            shift_q   <= i_dividend;
            rem_q     <= '0;
            count_q   <= '0;
          end
        end
        CALC: begin
          rem_q   <= rem_next_c;
          shift_q <= shift_next_c;
          count_q <= count_q + CW'(1);
          if (last_c) begin
            o_quotient    <= shift_next_c;
            o_remainder   <= rem_next_c;
            o_div_by_zero <= (divisor_q == '0);
            o_done        <= 1'b1;
          end
        end
        default: begin
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, start-while-busy,
// back-to-back issue, mid-operation reset and a randomized operand sweep
// checked against a plain-arithmetic reference model.
module tb_seq_divider;

  localparam int unsigned W = 8;
  localparam int LAT = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .o_busy       (busy),
    .o_done       (done),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
    .o_div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer division, divide-by-zero as all ones / dividend.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = W'(a / b);
      r = W'(a % b);
      z = 1'b0;
    end
  endfunction

  // Called at a falling edge: request is seen by the next rising edge, then
  // operand inputs are scrambled to show they are ignored while busy.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Watches falling edges after the start edge; lat counts edges including the start edge.
  task automatic wait_done(output int lat, output int busy_cycles, output bit overlap);
    lat = -1;
    busy_cycles = 0;
    overlap = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        lat = k;
        return;
      end
    end
  endtask

  task automatic test_reset;
    int lat, bc;
    bit ov;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b q=%0d r=%0d dbz=%0b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    // Release and request in the same cycle: the first rising edge must accept it.
    rst_n = 1'b1;
    start_op(8'd9, 8'd2);
    wait_done(lat, bc, ov);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL first_start_latency: got %0d required %0d", lat, LAT);
    end
    checks++;
    if (quotient !== 8'd4 || remainder !== 8'd1) begin
      errors++;
      $display("FAIL first_start_result: q=%0d r=%0d required q=4 r=1", quotient, remainder);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] av [8] = '{8'd200, 8'd255, 8'd5, 8'd255, 8'd100, 8'd0, 8'd1, 8'd0};
    logic [W-1:0] bv [8] = '{8'd7,   8'd1,   8'd9, 8'd255, 8'd0,   8'd1, 8'd255, 8'd0};
    logic [W-1:0] eq, er;
    logic ez;
    int lat, bc;
    bit ov;
    for (int i = 0; i < 8; i++) begin
      ref_div(av[i], bv[i], eq, er, ez);
      @(negedge clk);
      start_op(av[i], bv[i]);
      wait_done(lat, bc, ov);
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL directed_latency %0d/%0d: got %0d required %0d", av[i], bv[i], lat, LAT);
      end
      checks++;
      if (bc !== W) begin
        errors++;
        $display("FAIL directed_busy_cycles %0d/%0d: got %0d required %0d", av[i], bv[i], bc, W);
      end
      checks++;
      if (ov !== 1'b0) begin
        errors++;
        $display("FAIL directed_busy_done_overlap %0d/%0d: got 1 required 0", av[i], bv[i]);
      end
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
        errors++;
        $display("FAIL directed_result %0d/%0d: q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=%0b",
                 av[i], bv[i], quotient, remainder, div_by_zero, eq, er, ez);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq || remainder !== er) begin
        errors++;
        $display("FAIL directed_hold %0d/%0d: done=%0b busy=%0b q=%0d r=%0d required done=0 busy=0 q=%0d r=%0d",
                 av[i], bv[i], done, busy, quotient, remainder, eq, er);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat = -1;
    int bc;
    bit ov;
    @(negedge clk);
    start_op(8'd200, 8'd7);
    // A 50/5 request pulsed mid-operation must be ignored.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end
      if (k == 4) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL busy_start_latency: got %0d required %0d", lat, LAT);
    end
    checks++;
    if (quotient !== 8'd28 || remainder !== 8'd4) begin
      errors++;
      $display("FAIL busy_start_ignored: q=%0d r=%0d required q=28 r=4", quotient, remainder);
    end
    // Issue in the done cycle itself.
    start_op(8'd50, 8'd5);
    checks++;
    if (busy !== 1'b1 || quotient !== 8'd28 || remainder !== 8'd4) begin
      errors++;
      $display("FAIL b2b_accept_hold: busy=%0b q=%0d r=%0d required busy=1 q=28 r=4",
               busy, quotient, remainder);
    end
    wait_done(lat, bc, ov);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL b2b_latency: got %0d required %0d", lat, LAT);
    end
    checks++;
    if (quotient !== 8'd10 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: q=%0d r=%0d dbz=%0b required q=10 r=0 dbz=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    bit ov;
    bit seen_done = 1'b0;
    @(negedge clk);
    start_op(8'd200, 8'd7);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%0b done=%0b q=%0d r=%0d dbz=%0b required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done: activity seen after reset, required none");
    end
    start_op(8'd9, 8'd2);
    wait_done(lat, bc, ov);
    checks++;
    if (lat !== LAT || quotient !== 8'd4 || remainder !== 8'd1) begin
      errors++;
      $display("FAIL midreset_after: lat=%0d q=%0d r=%0d required lat=%0d q=4 r=1",
               lat, quotient, remainder, LAT);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, eq, er;
    logic ez;
    int lat, bc;
    bit ov;
    for (int i = 0; i < 2500; i++) begin
      a = W'($urandom);
      case (i % 8)
        0:       b = '0;
        1:       b = W'($urandom_range(1, 4));
        2:       b = W'($urandom_range(240, 255));
        default: b = W'($urandom);
      endcase
      if (i % 32 == 5) a = '1;
      ref_div(a, b, eq, er, ez);
      @(negedge clk);
      start_op(a, b);
      wait_done(lat, bc, ov);
      checks++;
      if (lat !== LAT || ov !== 1'b0) begin
        errors++;
        $display("FAIL rand_timing %0d/%0d: lat=%0d overlap=%0b required lat=%0d overlap=0",
                 a, b, lat, ov, LAT);
      end
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
        errors++;
        $display("FAIL rand_result %0d/%0d: q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=%0b",
                 a, b, quotient, remainder, div_by_zero, eq, er, ez);
      end
      if (b != 0) begin
        checks++;
        if ((int'(quotient) * int'(b) + int'(remainder)) != int'(a) || remainder >= b) begin
          errors++;
          $display("FAIL rand_identity %0d/%0d: q=%0d r=%0d violate q*d+r==n, r<d",
                   a, b, quotient, remainder);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
